// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Steps the select of an external 2**SEL_W:1 mux through every input,
//   holds each index for SETTLE+1 cycles, and samples the mux output on the
//   last cycle of each index. The samples form one word, which is offered on
//   a valid/ready handshake. All outputs are registered.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       begin a scan (accepted only when idle)
//   msb_first   scan order, latched with start: 0 = 0..N-1, 1 = N-1..0
//   mux_out     1-bit output of the mux being scanned
//   sel         select driven to the mux
//   busy        high while scanning or holding a word
//   word        assembled word, word[i] = sample taken with sel == i
//   word_valid  word is available
//   word_ready  consumer accepts word
//
// State | meaning
// IDLE  | waiting for start, sel parked at 0
// SCAN  | stepping sel, sampling mux_out once per index
// HOLD  | word presented, waiting for word_ready

module mux_scan_ctrl #(
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  msb_first,
  input  logic                  mux_out,
  output logic [SEL_W-1:0]      sel,
  output logic                  busy,
  output logic [2**SEL_W-1:0]   word,
  output logic                  word_valid,
  input  logic                  word_ready
);

  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
  localparam logic [7:0]       SETTLE_C = 8'(SETTLE);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] sel_nx;
  logic             busy_nx;
  logic [N-1:0]     word_nx;
  logic             valid_nx;
  logic [N-1:0]     shadow, shadow_nx;
  logic [7:0]       cnt, cnt_nx;
  logic             dir, dir_nx;
  logic             last_idx;

  // Last index depends on the direction latched at start.
  assign last_idx = dir ? (sel == '0) : (sel == SEL_LAST);

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    word_nx   = word;
    valid_nx  = word_valid;
    shadow_nx = shadow;
    cnt_nx    = cnt;
    dir_nx    = dir;
    case (state)
      IDLE: begin
        sel_nx = '0;
        if (start) begin
          state_nx = SCAN;
          dir_nx   = msb_first;
          sel_nx   = msb_first ? SEL_LAST : '0;
          cnt_nx   = '0;
        end
      end
      SCAN: begin
        if (cnt == SETTLE_C) begin
          shadow_nx[sel] = mux_out;
          if (last_idx) begin
            // Publish including the bit captured on this edge.
            word_nx  = shadow_nx;
            valid_nx = 1'b1;
            state_nx = HOLD;
          end else begin
            sel_nx = dir ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
            cnt_nx = '0;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      HOLD: begin
        if (word_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
          sel_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        sel_nx   = '0;
        valid_nx = 1'b0;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      busy       <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      shadow     <= '0;
      cnt        <= '0;
      dir        <= 1'b0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      busy       <= busy_nx;
      word       <= word_nx;
      word_valid <= valid_nx;
      shadow     <= shadow_nx;
      cnt        <= cnt_nx;
      dir        <= dir_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with SETTLE=1 and one with SETTLE=0
// share all stimulus. A cycle-level reference (elapsed-cycle arithmetic)
// predicts sel/busy/word/word_valid for each instance every cycle.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, msb_first, word_ready;
  logic [15:0] pat;

  logic [3:0]  sel1, sel0;
  logic        busy1, busy0, valid1, valid0, mux1, mux0;
  logic [15:0] word1, word0;

  assign mux1 = pat[sel1];
  assign mux0 = pat[sel0];

  mux_scan_ctrl #(.SEL_W(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .msb_first(msb_first),
    .mux_out(mux1), .sel(sel1), .busy(busy1), .word(word1),
    .word_valid(valid1), .word_ready(word_ready));

  mux_scan_ctrl #(.SEL_W(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .msb_first(msb_first),
    .mux_out(mux0), .sel(sel0), .busy(busy0), .word(word0),
    .word_valid(valid0), .word_ready(word_ready));

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int hs1      = 0;
  int t0       = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc_cnt);
    end
  endtask

  // Reference: phase 0 idle, 1 scanning, 2 holding; k = edges since start.
  typedef struct {
    int          phase;
    int          k;
    bit          dir;
    logic [15:0] word;
    bit          valid;
  } mdl_t;

  mdl_t m1 = '{default: 0};
  mdl_t m0 = '{default: 0};

  function automatic mdl_t step(input mdl_t m, input int s, input bit rst_ok,
                                input bit st, input bit msb, input bit rdy,
                                input logic [15:0] p);
    mdl_t r = m;
    if (!rst_ok) begin
      r = '{default: 0};
    end else begin
      case (m.phase)
        0: if (st) begin r.phase = 1; r.k = 0; r.dir = msb; end
        1: begin
          r.k = m.k + 1;
          if (r.k == 16 * (s + 1)) begin
            r.phase = 2;
            r.valid = 1'b1;
            r.word  = p;
          end
        end
        default: if (rdy) begin r.phase = 0; r.valid = 1'b0; end
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_sel(input mdl_t m, input int s);
    int idx;
    idx = m.k / (s + 1);
    if (m.phase == 1) return 4'(m.dir ? 15 - idx : idx);
    if (m.phase == 2) return m.dir ? 4'd0 : 4'd15;
    return 4'd0;
  endfunction

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    m1 <= step(m1, 1, rst_n, start, msb_first, word_ready, pat);
    m0 <= step(m0, 0, rst_n, start, msb_first, word_ready, pat);
    if (rst_n && valid1 && word_ready) hs1 <= hs1 + 1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sel_s1",   32'(sel1),   32'(exp_sel(m1, 1)));
      chk("busy_s1",  32'(busy1),  32'(m1.phase != 0));
      chk("word_s1",  32'(word1),  32'(m1.word));
      chk("valid_s1", 32'(valid1), 32'(m1.valid));
      chk("sel_s0",   32'(sel0),   32'(exp_sel(m0, 0)));
      chk("busy_s0",  32'(busy0),  32'(m0.phase != 0));
      chk("word_s0",  32'(word0),  32'(m0.word));
      chk("valid_s0", 32'(valid0), 32'(m0.valid));
    end
  end

  task automatic pulse_start(input bit msb);
    @(posedge clk); #2;
    msb_first = msb;
    start     = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    t0    = cyc_cnt;
  endtask

  // Waits for word_valid of the chosen instance; lat = edges since accept.
  task automatic wait_v(input bit which, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (which ? valid1 : valid0) begin
        lat = cyc_cnt - t0;
        break;
      end
    end
    if (lat < 0) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int l0, l1, hs_before, r1, r2;
    bit seen;
    rst_n = 1'b0; start = 1'b0; msb_first = 1'b0; word_ready = 1'b1; pat = '0;
    @(posedge clk); cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_sel",   32'(sel1),   32'd0);
    chk("rst_busy",  32'(busy1),  32'd0);
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_word",  32'(word1),  32'd0);
    rst_n = 1'b1;

    // LSB-first, 5555
    pat = 16'h5555;
    pulse_start(1'b0);
    wait_v(1'b0, l0);
    wait_v(1'b1, l1);
    chk("lat_settle0", 32'(l0), 32'd16);
    chk("lat_settle1", 32'(l1), 32'd32);
    chk("word_5555",   32'(word1), 32'h5555);
    @(posedge clk); #1;
    chk("idle_busy",  32'(busy1),  32'd0);
    chk("idle_valid", 32'(valid1), 32'd0);

    // MSB-first, mapping unchanged
    pat = 16'hA5C3;
    pulse_start(1'b1);
    wait_v(1'b1, l1);
    chk("lat_msb",    32'(l1),    32'd32);
    chk("word_a5c3",  32'(word1), 32'hA5C3);
    chk("word0_a5c3", 32'(word0), 32'hA5C3);

    // Backpressure with start pulsed during HOLD
    pat = 16'h1234;
    pulse_start(1'b0);
    word_ready = 1'b0;
    wait_v(1'b1, l1);
    chk("word_1234", 32'(word1), 32'h1234);
    hs_before = hs1;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_word",  32'(word1),  32'h1234);
      chk("bp_valid", 32'(valid1), 32'd1);
      chk("bp_busy",  32'(busy1),  32'd1);
    end
    start = 1'b0;
    word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_one_xfer", 32'(hs1 - hs_before), 32'd1);
    chk("bp_idle",     32'(busy1), 32'd0);

    // Reset mid-scan at cycle 10
    pat = 16'h0F0F;
    pulse_start(1'b0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_sel",   32'(sel1),   32'd0);
    chk("mid_rst_busy",  32'(busy1),  32'd0);
    chk("mid_rst_valid", 32'(valid1), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid1) seen = 1'b1;
    end
    chk("no_partial_word", 32'(seen), 32'd0);
    pulse_start(1'b1);
    wait_v(1'b1, l1);
    chk("after_rst_lat",  32'(l1),    32'd32);
    chk("after_rst_word", 32'(word1), 32'h0F0F);

    // SETTLE=0 instance, all ones
    pat = 16'hFFFF;
    pulse_start(1'b0);
    wait_v(1'b0, l0);
    chk("s0_lat",  32'(l0),    32'd16);
    chk("s0_word", 32'(word0), 32'hFFFF);
    wait_v(1'b1, l1);
    chk("s1_ffff", 32'(word1), 32'hFFFF);

    // start held high: back-to-back scans, 34-cycle period for SETTLE=1
    pat = 16'h3C3C;
    msb_first = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    wait_v(1'b1, l1);
    r1 = cyc_cnt;
    @(posedge clk); #1;
    wait_v(1'b1, l1);
    r2 = cyc_cnt;
    chk("b2b_period", 32'(r2 - r1), 32'd34);
    chk("b2b_word",   32'(word1),   32'h3C3C);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequential select driver and capture stage that sits directly upstream of the 16:1 mux (Comb_ckt/16to1mux.v). On a start pulse it steps the mux select through all 16 inputs, waits a settle time at each index, and samples the mux's 1-bit output. It assembles the samples into a 16-bit word and presents that word on a valid/ready handshake. Mux data inputs are outside this block; only sel and the mux output pass between the two.

Parameters:
SEL_W, 4, select width; N = 2**SEL_W inputs scanned (16 at default).
SETTLE, 1, extra cycles each index is held before sampling (0 legal; max 255).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin a scan; honoured only in IDLE
msb_first  input  1  scan order; 0 = index 0..N-1, 1 = N-1..0; latched on accepted start
mux_out  input  1  output of the 16:1 mux under control
sel  output  SEL_W  select driven to the mux
busy  output  1  high in SCAN and HOLD
word  output  N  assembled sample word; word[i] = mux_out sampled while sel==i
word_valid  output  1  word available
word_ready  input  1  consumer accepts word

Behaviour:
- Reset: rst_n sampled low at a clk edge -> state IDLE; sel=0, busy=0, word=0, word_valid=0; shadow register, index counter and settle counter all cleared. Reset overrides every other input and aborts any scan or hold in progress. No partial word is ever presented.
- FSM states: IDLE, SCAN, HOLD. All outputs are registered.
- IDLE: sel=0, busy=0. On start=1: latch msb_first, set sel to the first index (0, or N-1 if msb_first), clear the settle counter, go to SCAN.
- SCAN: each index is held for exactly SETTLE+1 cycles. At the edge where the settle counter equals SETTLE:
  - capture mux_out into shadow[sel];
  - if this was the last index, copy the shadow into word (including this bit), assert word_valid and go to HOLD;
  - otherwise step sel by +1 (LSB-first) or -1 (MSB-first) and clear the settle counter.
- Latency: word_valid rises N*(SETTLE+1) cycles after the edge that accepted start (32 cycles at defaults).
- HOLD: word and word_valid are held stable and busy=1. On word_valid && word_ready: clear word_valid and go to IDLE. word keeps its last value until the next completed scan.
- start is ignored in SCAN and HOLD, including the cycle in which the handshake completes. The next start can be accepted one cycle after that.
- msb_first changes only the sel sequence. word bit mapping is always word[i] = sample taken at sel==i.
- sel never leaves the range 0..N-1. No wrap-around occurs within a scan.

Test Plan:
- Mux inputs = 16'h5555, msb_first=0, SETTLE=1, word_ready=1, pulse start -> sel steps 0..15, 2 cycles per index; word=16'h5555 with word_valid high exactly 32 cycles after start; back in IDLE one cycle later.
- Inputs = 16'hA5C3, msb_first=1 -> sel sequence is 15,14,...,0; word=16'hA5C3 (mapping unchanged by order).
- Backpressure: word_ready=0 for 5 cycles after word_valid, start pulsed during HOLD -> word, word_valid and busy are stable; start is ignored; exactly one word is transferred when word_ready=1.
- rst_n low for 1 cycle mid-scan (cycle 10) -> next edge: sel=0, busy=0, word_valid=0; no word_valid follows; a fresh start then completes normally.
- SETTLE=0 build, inputs 16'hFFFF -> one cycle per index; word=16'hFFFF at 16 cycles.
- start held high continuously -> scans run back-to-back; each one begins one cycle after the previous handshake; no scan begins during SCAN or HOLD.
